mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Parametrised successor to the multicycle MIPS controller: a Moore FSM plus an integrated ALU decoder, driving the multicycle datapath.
- Covers R-type, LW, SW, BEQ, ADDI and J.
- Adds a memory-ready wait handshake, a combined PC enable and illegal-opcode detection with a saturating counter.
- Sits between the instruction register (Opcode/Funct) and datapath mux/enable controls.

## Interface
- ENABLE_ADDI, 1: 1 = ADDI decoded; 0 = ADDI treated as illegal.
- ENABLE_JUMP, 1: 1 = J decoded; 0 = J treated as illegal.
- MEM_WAIT, 1: 1 = memory states wait for MemReady; 0 = MemReady ignored, treated as 1.
- CNT_W, 8: width of IllegalCount.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- Opcode  in  6  instruction opcode from the IR.
- Funct  in  6  R-type function field.
- zero  in  1  ALU zero flag.
- MemReady  in  1  memory access completes this cycle.
- MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, RegWrite, Branch, PCWrite  out  1 each  datapath controls.
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2.
- ALUControl  out  3  ALU operation.
- PCEn  out  1  PCWrite | (Branch & zero).
- Illegal  out  1  one-cycle pulse on undecodable opcode.
- IllegalCount  out  CNT_W  saturating count of Illegal pulses.
- State  out  4  current state encoding (debug).

## Operation
- Opcodes:
  - R = 000000
  - LW = 100011
  - SW = 101011
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Any output not listed for a state is 0. No X outputs in any state.
- Per-state outputs and transitions:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=MemReady. Go to DECODE on MemReady, else hold.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Branch by opcode:
    - LW/SW -> MEMADR
    - R -> EXECUTE
    - BEQ -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - any other (including disabled ADDI/J) -> FETCH, with Illegal=1 this cycle.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMREAD; SW -> MEMWRITE.
  - MEMREAD: IorD=1. MemReady -> MEMWB, else hold.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
  - MEMWRITE: IorD=1, MemWrite=1 (held while waiting). MemReady -> FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH.
  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- ALU decoder (ALUOp is internal):
  - ALUOp 00 -> ALUControl 010 (add).
  - ALUOp 01 -> 110 (sub).
  - ALUOp 10, by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other Funct -> 010.
- IllegalCount increments by 1 on each Illegal pulse and saturates at 2^CNT_W-1; it never wraps.
- Unused state encodings 12-15 go to FETCH on the next edge, with all outputs 0.

## Timing
- reset low at a rising edge:
  - state <= FETCH and IllegalCount <= 0, regardless of MemReady or the current state (including mid-wait).
  - Outputs then show FETCH values, so IRWrite/PCWrite follow MemReady.
- Outputs are combinational from the registered state. PCEn, IRWrite, PCWrite and ALUControl also depend combinationally on zero, MemReady and Funct.
- Cycles per instruction with MemReady tied high:
  - LW 5
  - SW 4
  - R 4
  - ADDI 4
  - BEQ 3
  - J 3
  - illegal 2
- Each low-MemReady cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle; all controls are held stable during the wait.
- Opcode and Funct must be stable from DECODE until return to FETCH; the IR holds them because IRWrite=0 outside FETCH.
- Illegal asserts in the DECODE cycle. IllegalCount updates at the following edge.

## Test plan
- Reset/R-type: reset low 2 cycles, then high with MemReady=1. Opcode=000000, Funct=100010.
  - State sequence 0,1,6,7,0.
  - ALUControl=110 in EXECUTE; RegWrite=1 and RegDst=1 only in ALUWB.
- LW with waits: Opcode=100011, MemReady low 2 cycles in FETCH and 3 cycles in MEMREAD.
  - 10 cycles total.
  - IRWrite pulses once.
  - RegWrite=1 with MemToReg=1 in MEMWB only.
- SW wait, then reset: Opcode=101011, MemReady low in MEMWRITE; assert reset low mid-wait.
  - MemWrite=1 held until reset.
  - State=0 and MemWrite=0 on the next edge.
- BEQ: Opcode=000100, once with zero=1 and once with zero=0.
  - zero=1: PCEn=1 in BRANCH.
  - zero=0: PCEn=0 in BRANCH.
  - 3 cycles each; ALUControl=110.
- Disabled opcodes: ENABLE_JUMP=0, CNT_W=2, Opcode=000010 issued 5 times.
  - Each takes 2 cycles and pulses Illegal once.
  - IllegalCount reads 1,2,3,3,3.
- J/ADDI enabled: J gives 0,1,11,0 with PCSrc=10 and PCWrite=1 in JUMP. ADDI gives 0,1,9,10,0 with RegDst=0 and MemToReg=0 in ADDIWB.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM with an integrated ALU decoder, memory-ready
// wait states, a combined PC enable and a saturating illegal-opcode counter.
module mips_multicycle_ctrl #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter bit MEM_WAIT    = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             zero,
  input  logic             MemReady,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             Branch,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic             PCEn,
  output logic             Illegal,
  output logic [CNT_W-1:0] IllegalCount,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       alu_op;
  logic             dead;
  logic             mem_rdy;

  assign mem_rdy = MEM_WAIT ? MemReady : 1'b1;

  always_comb begin
    state_d  = state_q;
    MemToReg = 1'b0;
    RegDst   = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcB  = 2'b00;
    alu_op   = 2'b00;
    Illegal  = 1'b0;
    dead     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (Opcode == OP_LW || Opcode == OP_SW)       state_d = S_MEMADR;
        else if (Opcode == OP_R)                      state_d = S_EXECUTE;
        else if (Opcode == OP_BEQ)                    state_d = S_BRANCH;
        else if (ENABLE_ADDI && Opcode == OP_ADDI)    state_d = S_ADDIEX;
        else if (ENABLE_JUMP && Opcode == OP_J)       state_d = S_JUMP;
        else begin
          Illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        // Unreachable encodings recover to FETCH with every output forced low.
        dead    = 1'b1;
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
    if (dead) ALUControl = 3'b000;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Illegal && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCEn         = PCWrite | (Branch & zero);
  assign IllegalCount = cnt_q;
  assign State        = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a default instance and one with J disabled
// and a 2-bit illegal counter, both checked cycle by cycle against hand-derived vectors.
module tb_mips_multicycle_ctrl;

  // Control vector order: MemToReg RegDst IorD ALUSrcA IRWrite MemWrite RegWrite Branch
  // PCWrite | PCSrc | ALUSrcB | ALUControl | PCEn | Illegal
  localparam logic [17:0] C_FETCH1  = 18'b0_0_0_0_1_0_0_0_1_00_01_010_1_0;
  localparam logic [17:0] C_FETCH0  = 18'b0_0_0_0_0_0_0_0_0_00_01_010_0_0;
  localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_00_11_010_0_0;
  localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_00_11_010_0_1;
  localparam logic [17:0] C_MEMADR  = 18'b0_0_0_1_0_0_0_0_0_00_10_010_0_0;
  localparam logic [17:0] C_MEMREAD = 18'b0_0_1_0_0_0_0_0_0_00_00_010_0_0;
  localparam logic [17:0] C_MEMWB   = 18'b1_0_0_0_0_0_1_0_0_00_00_010_0_0;
  localparam logic [17:0] C_MEMWR   = 18'b0_0_1_0_0_1_0_0_0_00_00_010_0_0;
  localparam logic [17:0] C_EXE_SUB = 18'b0_0_0_1_0_0_0_0_0_00_00_110_0_0;
  localparam logic [17:0] C_ALUWB   = 18'b0_1_0_0_0_0_1_0_0_00_00_010_0_0;
  localparam logic [17:0] C_BR1     = 18'b0_0_0_1_0_0_0_1_0_01_00_110_1_0;
  localparam logic [17:0] C_BR0     = 18'b0_0_0_1_0_0_0_1_0_01_00_110_0_0;
  localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_1_0_0_00_00_010_0_0;
  localparam logic [17:0] C_JUMP    = 18'b0_0_0_0_0_0_0_0_1_10_00_010_1_0;

  logic       clk, reset, rst2, zero, MemReady;
  logic [5:0] Opcode, op2, Funct;

  logic MemToReg_a, RegDst_a, IorD_a, ALUSrcA_a, IRWrite_a, MemWrite_a, RegWrite_a;
  logic Branch_a, PCWrite_a, PCEn_a, Illegal_a;
  logic [1:0] PCSrc_a, ALUSrcB_a;
  logic [2:0] ALUControl_a;
  logic [7:0] cnt_a;
  logic [3:0] State_a;

  logic MemToReg_b, RegDst_b, IorD_b, ALUSrcA_b, IRWrite_b, MemWrite_b, RegWrite_b;
  logic Branch_b, PCWrite_b, PCEn_b, Illegal_b;
  logic [1:0] PCSrc_b, ALUSrcB_b;
  logic [2:0] ALUControl_b;
  logic [1:0] cnt_b;
  logic [3:0] State_b;

  mips_multicycle_ctrl dut_a (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .zero(zero),
    .MemReady(MemReady), .MemToReg(MemToReg_a), .RegDst(RegDst_a), .IorD(IorD_a),
    .ALUSrcA(ALUSrcA_a), .IRWrite(IRWrite_a), .MemWrite(MemWrite_a),
    .RegWrite(RegWrite_a), .Branch(Branch_a), .PCWrite(PCWrite_a), .PCSrc(PCSrc_a),
    .ALUSrcB(ALUSrcB_a), .ALUControl(ALUControl_a), .PCEn(PCEn_a), .Illegal(Illegal_a),
    .IllegalCount(cnt_a), .State(State_a)
  );

  mips_multicycle_ctrl #(.ENABLE_JUMP(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst2), .Opcode(op2), .Funct(Funct), .zero(zero),
    .MemReady(MemReady), .MemToReg(MemToReg_b), .RegDst(RegDst_b), .IorD(IorD_b),
    .ALUSrcA(ALUSrcA_b), .IRWrite(IRWrite_b), .MemWrite(MemWrite_b),
    .RegWrite(RegWrite_b), .Branch(Branch_b), .PCWrite(PCWrite_b), .PCSrc(PCSrc_b),
    .ALUSrcB(ALUSrcB_b), .ALUControl(ALUControl_b), .PCEn(PCEn_b), .Illegal(Illegal_b),
    .IllegalCount(cnt_b), .State(State_b)
  );

  logic [17:0] act_a, act_b;
  assign act_a = {MemToReg_a, RegDst_a, IorD_a, ALUSrcA_a, IRWrite_a, MemWrite_a,
                  RegWrite_a, Branch_a, PCWrite_a, PCSrc_a, ALUSrcB_a, ALUControl_a,
                  PCEn_a, Illegal_a};
  assign act_b = {MemToReg_b, RegDst_b, IorD_b, ALUSrcA_b, IRWrite_b, MemWrite_b,
                  RegWrite_b, Branch_b, PCWrite_b, PCSrc_b, ALUSrcB_b, ALUControl_b,
                  PCEn_b, Illegal_b};

  typedef struct {
    bit          w;
    int          tag;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   seq    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic cmp(input int tag, input string what, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL step%0d %s: got %0h want %0h", tag, what, got, want);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.w) begin
        cmp(e.tag, "dutA_state", 32'(State_a), 32'(e.st));
        cmp(e.tag, "dutA_ctl",   32'(act_a),   32'(e.ctl));
        cmp(e.tag, "dutA_cnt",   32'(cnt_a),   32'(e.cnt));
      end else begin
        cmp(e.tag, "dutB_state", 32'(State_b), 32'(e.st));
        cmp(e.tag, "dutB_ctl",   32'(act_b),   32'(e.ctl));
        cmp(e.tag, "dutB_cnt",   32'(cnt_b),   32'(e.cnt));
      end
    end
  end

  task automatic chk(input bit w, input logic mr, input logic z, input logic [3:0] st,
                     input logic [17:0] ctl, input logic [7:0] cnt);
    exp_t e;
    MemReady = mr;
    zero     = z;
    e = '{w: w, tag: seq, st: st, ctl: ctl, cnt: cnt};
    q.push_back(e);
    seq++;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] cnt_tab [5];

  initial begin
    cnt_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
    reset    = 1'b0;
    rst2     = 1'b0;
    Opcode   = 6'b000000;
    Funct    = 6'b100010;
    op2      = 6'b000010;
    MemReady = 1'b1;
    zero     = 1'b0;
    @(posedge clk);
    #1;
    // Reset, then R-type SUB
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    reset = 1'b1;
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    chk(0, 1, 0, 4'd1, C_DECODE, 8'd0);
    chk(0, 1, 0, 4'd6, C_EXE_SUB, 8'd0);
    chk(0, 1, 0, 4'd7, C_ALUWB, 8'd0);
    // Undecodable opcode on the default instance
    Opcode = 6'b111111;
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    chk(0, 1, 0, 4'd1, C_DEC_ILL, 8'd0);
    // LW with 2 fetch waits and 3 read waits
    Opcode = 6'b100011;
    chk(0, 0, 0, 4'd0, C_FETCH0, 8'd1);
    chk(0, 0, 0, 4'd0, C_FETCH0, 8'd1);
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd1);
    chk(0, 1, 0, 4'd1, C_DECODE, 8'd1);
    chk(0, 1, 0, 4'd2, C_MEMADR, 8'd1);
    for (int i = 0; i < 3; i++) chk(0, 0, 0, 4'd3, C_MEMREAD, 8'd1);
    chk(0, 1, 0, 4'd3, C_MEMREAD, 8'd1);
    chk(0, 1, 0, 4'd4, C_MEMWB, 8'd1);
    // SW stalled in MEMWRITE, aborted by reset
    Opcode = 6'b101011;
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd1);
    chk(0, 1, 0, 4'd1, C_DECODE, 8'd1);
    chk(0, 1, 0, 4'd2, C_MEMADR, 8'd1);
    chk(0, 0, 0, 4'd5, C_MEMWR, 8'd1);
    chk(0, 0, 0, 4'd5, C_MEMWR, 8'd1);
    reset = 1'b0;
    chk(0, 0, 0, 4'd5, C_MEMWR, 8'd1);
    reset  = 1'b1;
    Opcode = 6'b000100;
    chk(0, 0, 0, 4'd0, C_FETCH0, 8'd0);
    // BEQ taken, then not taken
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    chk(0, 1, 1, 4'd1, C_DECODE, 8'd0);
    chk(0, 1, 1, 4'd8, C_BR1, 8'd0);
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    chk(0, 1, 0, 4'd1, C_DECODE, 8'd0);
    chk(0, 1, 0, 4'd8, C_BR0, 8'd0);
    // J
    Opcode = 6'b000010;
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    chk(0, 1, 0, 4'd1, C_DECODE, 8'd0);
    chk(0, 1, 0, 4'd11, C_JUMP, 8'd0);
    // ADDI
    Opcode = 6'b001000;
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    chk(0, 1, 0, 4'd1, C_DECODE, 8'd0);
    chk(0, 1, 0, 4'd9, C_MEMADR, 8'd0);
    chk(0, 1, 0, 4'd10, C_ADDIWB, 8'd0);
    chk(0, 1, 0, 4'd0, C_FETCH1, 8'd0);
    // Disabled J on the second instance: saturating 2-bit counter
    rst2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk(1, 1, 0, 4'd0, C_FETCH1, cnt_tab[i]);
      chk(1, 1, 0, 4'd1, C_DEC_ILL, cnt_tab[i]);
    end
    chk(1, 1, 0, 4'd0, C_FETCH1, 8'd3);

    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
